// File: rtl/nuc_pattern_scanner.sv
// Walks a nucleotide memory range one read per cycle and counts overlapping matches against a programmed pattern.
// Latency: length+1 cycles from accepted start to done. Backpressure: none; start is only accepted in IDLE or DONE.
module nuc_pattern_scanner #(
  parameter int AW   = 16,
  parameter int PLEN = 4,
  parameter int CW   = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [2*PLEN-1:0] pattern,
  input  logic [AW-1:0]     base_addr,
  input  logic [AW:0]       length,
  output logic              mem_re,
  output logic [AW-1:0]     mem_addr,
  input  logic [1:0]        mem_data,
  output logic              busy,
  output logic              done,
  output logic [CW-1:0]     match_count,
  output logic              found,
  output logic [AW-1:0]     first_match_addr
);

  localparam int FW = $clog2(PLEN + 1);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t            state, state_nxt;
  logic [2*PLEN-1:0] pat_q;
  logic [2*PLEN-3:0] window;
  logic [2*PLEN-1:0] shifted;
  logic [AW-1:0]     cur_addr;
  logic [AW:0]       remaining;
  logic [FW-1:0]     fill;
  logic              accept;
  logic              hit;

  assign accept  = start && (state == IDLE || state == DONE);
  assign shifted = {window, mem_data};
  // A full window needs PLEN-1 earlier nucleotides plus the one arriving this cycle.
  assign hit     = (state == SCAN) && (fill >= FW'(PLEN - 1)) && (shifted == pat_q);

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: if (start) state_nxt = (length != '0) ? SCAN : DONE;
      SCAN:       if (remaining == (AW+1)'(1)) state_nxt = DONE;
      default:    state_nxt = IDLE;
    endcase
  end

  always_comb begin
    mem_re   = (state == SCAN);
    busy     = (state == SCAN);
    done     = (state == DONE);
    mem_addr = cur_addr;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pat_q            <= '0;
      window           <= '0;
      cur_addr         <= '0;
      remaining        <= '0;
      fill             <= '0;
      match_count      <= '0;
      found            <= 1'b0;
      first_match_addr <= '0;
    end else if (accept) begin
      pat_q            <= pattern;
      cur_addr         <= base_addr;
      remaining        <= length;
      window           <= '0;
      fill             <= '0;
      match_count      <= '0;
      found            <= 1'b0;
      first_match_addr <= '0;
    end else if (state == SCAN) begin
      window    <= shifted[2*PLEN-3:0];
      cur_addr  <= cur_addr + AW'(1);
      remaining <= remaining - (AW+1)'(1);
      if (fill != FW'(PLEN)) fill <= fill + FW'(1);
      if (hit) begin
        if (match_count != '1) match_count <= match_count + CW'(1);
        if (!found) begin
          found            <= 1'b1;
          first_match_addr <= cur_addr - AW'(PLEN - 1);
        end
      end
    end
  end

endmodule
